// File: rtl/birth_digit_checker.sv
// Checks a BCD digit stream against a stored birthday pattern and counts completed matches.
// Restart after a mismatch looks only at the first pattern digit. Matches never overlap.
module birth_digit_checker #(
  parameter int          N_DIGITS = 8,
  parameter logic [31:0] PATTERN  = 32'h19990728
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clr_cnt,
  output logic [3:0] progress,
  output logic       match,
  output logic       bad_digit,
  output logic [7:0] match_cnt
);

  localparam logic [2:0] LAST = 3'(N_DIGITS - 1);

  // Table slot i holds the i-th expected digit. The first digit comes from the top nibble.
  logic [7:0][3:0] pat;
  for (genvar i = 0; i < 8; i++) begin : g_pat
    if (i < N_DIGITS) begin : g_used
      assign pat[i] = PATTERN[4*(N_DIGITS-1-i) +: 4];
    end else begin : g_unused
      assign pat[i] = 4'h0;
    end
  end

  logic [2:0] prog, prog_nxt;
  logic       match_nxt, bad_nxt;

  always_comb begin
    prog_nxt  = prog;
    match_nxt = 1'b0;
    bad_nxt   = 1'b0;
    if (digit_valid) begin
      if (digit > 4'd9) begin
        prog_nxt = 3'd0;
        bad_nxt  = 1'b1;
      end else if (digit == pat[prog]) begin
        if (prog == LAST) begin
          prog_nxt  = 3'd0;
          match_nxt = 1'b1;
        end else begin
          prog_nxt = prog + 3'd1;
        end
      end else begin
        prog_nxt = (digit == pat[0]) ? 3'd1 : 3'd0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prog      <= 3'd0;
      match     <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      prog      <= prog_nxt;
      match     <= match_nxt;
      bad_digit <= bad_nxt;
    end
  end

  // A clear wins over a match on the same edge. The count saturates at 255.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      match_cnt <= 8'd0;
    else if (clr_cnt)
      match_cnt <= 8'd0;
    else if (match_nxt && match_cnt != 8'hFF)
      match_cnt <= match_cnt + 8'd1;
  end

  assign progress = {1'b0, prog};

endmodule
